rv32i_encoder: RTL

//  Inverse of the decode stage: packs decoded RV32I fields (opcode, rd, rs1, rs2, fun3, fun7, imm, type) into a
//  32-bit instruction word. Used to synthesise instruction streams for ins_mem preload and decode round-trip checks.

---
 rtl/rv32i_encoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rv32i_encoder.sv
// rv32i_encoder: packs decoded RV32I fields into a 32-bit instruction word.
// Valid/ready input, 2-entry output FIFO of {err,word}, valid/ready output,
// accepted-bundle counter (wrapping) and error counter (saturating).
// Optional feature: define RV32I_ENC_RANGE_CHECK_EN to also flag immediates
// that do not fit the selected instruction format.
module rv32i_encoder #(
    parameter int N_param = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         INST_typ_i,
    input  logic [6:0]         opcode_i,
    input  logic [4:0]         rd_i,
    input  logic [4:0]         rs1_i,
    input  logic [4:0]         rs2_i,
    input  logic [2:0]         fun3_i,
    input  logic [6:0]         fun7_i,
    input  logic [N_param-1:0] imm_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_param-1:0] instruction_o,
    output logic               err_o,
    output logic [CNT_W-1:0]   enc_count_o,
    output logic [7:0]         ill_count_o
);

    localparam logic [N_param-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t         state, state_nxt;

    logic [2:0]         type_ones;
    logic               type_legal;
    logic [N_param-1:0] enc_word;
    logic               range_err;
    logic               enc_err;
    logic               push, pop;

    logic [N_param:0]   head_q;
    logic [N_param:0]   tail_q;

    // Type legality: exactly one of bits [5:0] set and reserved bit clear
    always_comb begin
        type_ones = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            type_ones = type_ones + {2'b00, INST_typ_i[i]};
        end
        type_legal = (type_ones == 3'd1) && !INST_typ_i[6];
    end

    // Field packing for each instruction format; illegal types become a NOP
    always_comb begin
        enc_word = '0;
        if (!type_legal) begin
            enc_word = NOP_WORD;
        end else if (INST_typ_i[0]) begin
            enc_word = {fun7_i, rs2_i, rs1_i, fun3_i, rd_i, opcode_i};
        end else if (INST_typ_i[1]) begin
            enc_word = {imm_i[11:0], rs1_i, fun3_i, rd_i, opcode_i};
        end else if (INST_typ_i[2]) begin
            enc_word = {imm_i[11:5], rs2_i, rs1_i, fun3_i, imm_i[4:0], opcode_i};
        end else if (INST_typ_i[3]) begin
            enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, fun3_i,
                        imm_i[4:1], imm_i[11], opcode_i};
        end else if (INST_typ_i[4]) begin
            enc_word = {imm_i[31:12], rd_i, opcode_i};
        end else begin
            enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                        rd_i, opcode_i};
        end
    end

`ifdef RV32I_ENC_RANGE_CHECK_EN
    // Flag immediates that lose information when truncated to the format
    always_comb begin
        range_err = 1'b0;
        if (type_legal) begin
            if (INST_typ_i[1] || INST_typ_i[2]) begin
                range_err = !((imm_i[31:11] == '0) || (imm_i[31:11] == '1));
            end else if (INST_typ_i[3]) begin
                range_err = imm_i[0] ||
                            !((imm_i[31:12] == '0) || (imm_i[31:12] == '1));
            end else if (INST_typ_i[5]) begin
                range_err = imm_i[0] ||
                            !((imm_i[31:20] == '0) || (imm_i[31:20] == '1));
            end else if (INST_typ_i[4]) begin
                range_err = (imm_i[11:0] != '0);
            end
        end
    end
`else
    // Immediates are silently truncated; only the type can be in error
    always_comb begin
        range_err = 1'b0;
    end
`endif

    assign enc_err = !type_legal || range_err;

    // Buffer occupancy register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Occupancy next-state and handshake outputs (handshakes depend on state only)
    always_comb begin
        state_nxt = state;
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = FULL;
                else if (pop && !push) state_nxt = EMPTY;
            end
            FULL:  if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // FIFO storage: head is always the entry presented at the output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (pop) begin
            if (state == FULL) begin
                head_q <= tail_q;
            end else if (push) begin
                head_q <= {enc_err, enc_word};
            end
        end else if (push) begin
            if (state == EMPTY) begin
                head_q <= {enc_err, enc_word};
            end else begin
                tail_q <= {enc_err, enc_word};
            end
        end
    end

    assign instruction_o = out_valid ? head_q[N_param-1:0] : '0;
    assign err_o         = out_valid ? head_q[N_param] : 1'b0;

    // Accepted-bundle counter (wraps) and error counter (saturates)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enc_count_o <= '0;
            ill_count_o <= '0;
        end else if (push) begin
            enc_count_o <= enc_count_o + 1'b1;
            if (enc_err && (ill_count_o != 8'hFF)) begin
                ill_count_o <= ill_count_o + 8'd1;
            end
        end
    end

endmodule
